// File: rtl/rs_station.sv
// rs_station: reservation station between dispatch and the ALU.
// Holds DEPTH renamed instructions, captures pending operands from NUM_CDB
// broadcast channels and issues one operand-complete entry per cycle.
// Optional feature: define RS_AGE_ISSUE_EN to issue the oldest ready entry
// (age matrix); otherwise the lowest-index ready entry issues.

// Operand wakeup for one pending operand: lowest matching channel wins.
module rs_station_wake #(
  parameter int TAG_W   = 4,
  parameter int NUM_CDB = 2
) (
  input  logic                     pend,
  input  logic [TAG_W-1:0]         tag,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]    cdb_value,
  output logic                     hit,
  output logic [31:0]              val
);
  // scan high to low so the lowest channel index overrides
  always_comb begin
    hit = 1'b0;
    val = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (pend && cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == tag)) begin
        hit = 1'b1;
        val = cdb_value[c*32 +: 32];
      end
    end
  end
endmodule

module rs_station #(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     jump_wrong,
  input  logic                     in_valid,
  input  logic [OP_W-1:0]          in_op,
  input  logic [31:0]              in_vj,
  input  logic [31:0]              in_vk,
  input  logic                     in_qj_busy,
  input  logic                     in_qk_busy,
  input  logic [TAG_W-1:0]         in_qj,
  input  logic [TAG_W-1:0]         in_qk,
  input  logic [31:0]              in_imm,
  input  logic [31:0]              in_pc,
  input  logic [TAG_W-1:0]         in_rob_tag,
  output logic                     full,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]    cdb_value,
  output logic                     out_valid,
  output logic [OP_W-1:0]          out_op,
  output logic [31:0]              out_vj,
  output logic [31:0]              out_vk,
  output logic [31:0]              out_imm,
  output logic [31:0]              out_pc,
  output logic [TAG_W-1:0]         out_rob_tag
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic             qj_busy;
    logic             qk_busy;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [TAG_W-1:0] rob_tag;
  } ent_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [TAG_W-1:0] rob_tag;
  } iss_t;

  logic [DEPTH-1:0]       busy_q, busy_d;
  ent_t                   ent_q [DEPTH];
  ent_t                   ent_d [DEPTH];
  iss_t                   iss_q, iss_d;
  logic                   out_valid_q, out_valid_d;

  logic [DEPTH-1:0]       wj_hit, wk_hit;
  logic [DEPTH-1:0][31:0] wj_val, wk_val;
  logic                   dj_hit, dk_hit;
  logic [31:0]            dj_val, dk_val;
  logic [DEPTH-1:0]       ready, cand;
  logic [IDX_W-1:0]       sel_idx, free_idx;
  logic                   sel_vld, alloc;
  logic [CNT_W-1:0]       occ;

  // per-entry operand wakeup and readiness (readiness uses stored flags only,
  // so an operand captured at an edge is selectable from the next edge)
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_station_wake #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_wj (
      .pend(busy_q[g] && ent_q[g].qj_busy), .tag(ent_q[g].qj),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .hit(wj_hit[g]), .val(wj_val[g]));
    rs_station_wake #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_wk (
      .pend(busy_q[g] && ent_q[g].qk_busy), .tag(ent_q[g].qk),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .hit(wk_hit[g]), .val(wk_val[g]));
    assign ready[g] = busy_q[g] && !ent_q[g].qj_busy && !ent_q[g].qk_busy;
  end

  // same-cycle capture for the operands of the incoming instruction
  rs_station_wake #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_dj (
    .pend(in_qj_busy), .tag(in_qj),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .hit(dj_hit), .val(dj_val));
  rs_station_wake #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_dk (
    .pend(in_qk_busy), .tag(in_qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .hit(dk_hit), .val(dk_val));

  // occupancy count; full ignores any slot being freed this cycle
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + CNT_W'(busy_q[i]);
  end
  assign full  = (occ == CNT_W'(DEPTH));
  assign alloc = in_valid && !full && rdy && !jump_wrong;

`ifdef RS_AGE_ISSUE_EN
  // older_q[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

  // a ready entry is a candidate only if no other ready entry is older
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && older_q[j][i]) cand[i] = 1'b0;
    end
  end

  // a newly allocated entry becomes younger than every other entry
  always_comb begin
    older_d = older_q;
    if (alloc) begin
      for (int j = 0; j < DEPTH; j++) begin
        older_d[free_idx][j] = 1'b0;
        older_d[j][free_idx] = (IDX_W'(j) != free_idx);
      end
    end
  end

  // age matrix register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) older_q <= '0;
    else      older_q <= older_d;
  end
`else
  assign cand = ready;
`endif

  // lowest-index pickers for issue and for the free slot
  always_comb begin
    sel_vld  = |cand;
    sel_idx  = '0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i])    sel_idx  = IDX_W'(i);
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
  end

  // next state: flush, else (when enabled) wakeup + issue + dispatch on disjoint entries
  always_comb begin
    busy_d      = busy_q;
    iss_d       = iss_q;
    out_valid_d = 1'b0;
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    if (jump_wrong) begin
      busy_d = '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wj_hit[i]) begin
          ent_d[i].vj      = wj_val[i];
          ent_d[i].qj_busy = 1'b0;
        end
        if (wk_hit[i]) begin
          ent_d[i].vk      = wk_val[i];
          ent_d[i].qk_busy = 1'b0;
        end
      end
      if (sel_vld) begin
        out_valid_d     = 1'b1;
        busy_d[sel_idx] = 1'b0;
        iss_d.op        = ent_q[sel_idx].op;
        iss_d.vj        = ent_q[sel_idx].vj;
        iss_d.vk        = ent_q[sel_idx].vk;
        iss_d.imm       = ent_q[sel_idx].imm;
        iss_d.pc        = ent_q[sel_idx].pc;
        iss_d.rob_tag   = ent_q[sel_idx].rob_tag;
      end
      if (alloc) begin
        busy_d[free_idx]          = 1'b1;
        ent_d[free_idx].op        = in_op;
        ent_d[free_idx].vj        = dj_hit ? dj_val : in_vj;
        ent_d[free_idx].vk        = dk_hit ? dk_val : in_vk;
        ent_d[free_idx].qj_busy   = in_qj_busy && !dj_hit;
        ent_d[free_idx].qk_busy   = in_qk_busy && !dk_hit;
        ent_d[free_idx].qj        = in_qj;
        ent_d[free_idx].qk        = in_qk;
        ent_d[free_idx].imm       = in_imm;
        ent_d[free_idx].pc        = in_pc;
        ent_d[free_idx].rob_tag   = in_rob_tag;
      end
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q      <= '0;
      iss_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      busy_q      <= busy_d;
      iss_q       <= iss_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op      = iss_q.op;
  assign out_vj      = iss_q.vj;
  assign out_vk      = iss_q.vk;
  assign out_imm     = iss_q.imm;
  assign out_pc      = iss_q.pc;
  assign out_rob_tag = iss_q.rob_tag;
endmodule

// File: doc/rs_station.md
# rs_station

Parametrised reservation station for the out-of-order RISC-V core. It sits between dispatch (decoder and rename) and the ALU. It holds up to `DEPTH` renamed instructions and captures missing operands from `NUM_CDB` broadcast channels (ALU, LSB, …). Each cycle it issues one operand-complete entry to the ALU, and it is flushed whole when the ROB reports a mispredict.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `TAG_W`, 4: ROB tag width.
- `OP_W`, 6: decoded opcode width.
- `NUM_CDB`, 2: number of common-data-bus channels.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable; when low, entries hold.
- `jump_wrong` in 1: ROB mispredict flush.
- `in_valid` in 1: dispatch request.
- `in_op` in OP_W: opcode.
- `in_vj`, `in_vk` in 32: operand values.
- `in_qj_busy`, `in_qk_busy` in 1: operand still pending.
- `in_qj`, `in_qk` in TAG_W: producer ROB tags.
- `in_imm`, `in_pc` in 32: immediate and PC.
- `in_rob_tag` in TAG_W: destination ROB tag.
- `full` out 1: no free entry, combinational from occupancy.
- `cdb_valid` in NUM_CDB: per-channel broadcast valid.
- `cdb_tag` in NUM_CDB*TAG_W: channel c occupies bits [c*TAG_W +: TAG_W].
- `cdb_value` in NUM_CDB*32: channel c occupies bits [c*32 +: 32].
- `out_valid` out 1: issue valid; ALU always accepts.
- `out_op` out OP_W, `out_vj` out 32, `out_vk` out 32, `out_imm` out 32, `out_pc` out 32, `out_rob_tag` out TAG_W: the issued entry's fields.

## Operation
- Entry fields: busy, op, vj/vk, qj/qk with busy flags, imm, pc, rob_tag, plus relative age.
- Ready entry: busy, with both operands non-pending.
- Allocation: `in_valid && !full && rdy` writes the lowest-index free entry.
- `full` = (occupancy == `DEPTH`). A slot freed by an issue in the same cycle does not lift `full`. Dispatch while `full` is dropped silently, with no state change.
- Wakeup on stored entries:
  - Every edge with `rdy`, any busy entry operand whose pending tag equals `cdb_tag[c]` with `cdb_valid[c]` captures `cdb_value[c]` and clears its pending flag.
  - If several channels match one operand, the lowest channel index wins.
  - Both operands may wake in the same edge.
- Wakeup on dispatch (always built): an incoming pending operand matching a valid CDB channel in the dispatch cycle is stored as already captured.
- Issue:
  - Each edge with `rdy`, one ready entry is selected per the Configuration policy.
  - The selected entry is freed at that edge.
  - Its fields are registered onto the `out_*` ports with `out_valid`=1.
  - If no entry is ready, `out_valid`=0 and the `out_*` data holds its previous value.
- An entry woken at edge E is selectable at edge E+1, never at E.
- `rdy`=0: entries, occupancy and ages hold; `out_valid` is 0 after the edge.
- Priority per edge: `rst` > `jump_wrong` > `rdy` gating > normal update.
  - Normal update performs dispatch, wakeup and issue together, on disjoint entries.
- `jump_wrong`=1 at an edge: all entries freed, occupancy 0, `out_valid`=0. The same-cycle dispatch and CDB data are discarded. This holds regardless of `rdy`.

## Timing
- Reset (async assert, sync release): all busy=0, `out_valid`=0, `out_op`/`out_vj`/`out_vk`/`out_imm`/`out_pc`=0, `out_rob_tag`=0, `full`=0.
- Minimum latency:
  - Dispatch with both operands present at edge E0 gives `out_valid` after edge E0+1.
  - Operand woken by CDB at E1 gives issue visible after E1+1.
- Throughput: one issue per cycle. Sustained dispatch plus issue at occupancy `DEPTH`-1 holds steady state without loss.
- Reset asserted mid-operation clears state immediately, without waiting for an edge.

## Configuration
- `RS_AGE_ISSUE_EN` defined:
  - Selection picks the oldest ready entry by dispatch order.
  - Relative age is preserved across frees and reallocation; implementation free (age matrix or per-entry counters).
- Not defined: selection picks the lowest-index ready entry; no age state is built.

## Test plan
- Reset, then dispatch op=3, vj=5, vk=7, tag=2, no pending operands → `out_valid`=1 two edges later with `out_vj`=5, `out_vk`=7, `out_rob_tag`=2; `full`=0 throughout.
- Dispatch an entry with qj=4 pending → not issued. CDB ch1 tag=4, value=0xDEAD → issued the edge after capture with `out_vj`=0xDEAD.
- Dispatch with qk=6 in the same cycle as CDB ch0 tag=6, value=9 → stored captured, issued next edge with `out_vk`=9.
- Fill all 16 entries pending on tag 1 → `full`=1; a 17th dispatch is dropped. Broadcast tag 1 → 16 issues on consecutive edges in policy order, then `full`=0.
- A pending in slot 0, B pending in slot 1, issue A, dispatch C into slot 0, wake B and C on the same edge → B first if `RS_AGE_ISSUE_EN`, otherwise C first.
- Occupancy 5 with ready entries, assert `jump_wrong` together with a dispatch → next edge `out_valid`=0, `full`=0, no further issues. Hold `rdy`=0 → no issue and no capture.
